// File: rtl/alu_mc_if.sv
// Operation/result handshake bundle for alu_mc.
// The master side offers operations and consumes results; the slave side is the ALU.
interface alu_mc_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;
  logic            busy;

  modport master (
    output in_valid, instruction, in1, in2, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, instruction, in1, in2, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV-style R-type integer ALU with a valid/ready handshake.
// Operands are captured at accept; the result is combinational from the captured
// operands and is only driven while out_valid is high.
// Optional macro ALU_MC_MUL_EN adds an iterative shift-add MUL (funct7=0000001,
// funct3=0), one multiplier bit per cycle.
module alu_mc #(
  parameter int XLEN = 64,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
`ifdef ALU_MC_MUL_EN
    MUL  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            in_ready;
  logic            accept;

  // Captured operation: only the decode fields the datapath actually uses
  logic [2:0]      funct3;
  logic            alt;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] result;

`ifdef ALU_MC_MUL_EN
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);
  logic            is_mul;
  logic            is_mul_in;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] acc;
`endif

  function automatic logic [XLEN-1:0] base_op(
    input logic [2:0]      f3,
    input logic            f7_alt,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [SHW-1:0]         sh;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    case (f3)
      3'd0: base_op = f7_alt ? (a - b) : (a + b);
      3'd1: base_op = a << sh;
      3'd2: base_op = {{(XLEN-1){1'b0}}, (sa < sb)};
      3'd3: base_op = {{(XLEN-1){1'b0}}, (a < b)};
      3'd4: base_op = a ^ b;
      3'd5: base_op = f7_alt ? XLEN'(sa >>> sh) : (a >> sh);
      3'd6: base_op = a | b;
      default: base_op = a & b;
    endcase
  endfunction

  assign accept = bus.in_valid && in_ready;

`ifdef ALU_MC_MUL_EN
  assign is_mul_in = (bus.instruction[31:25] == 7'b0000001) && (bus.instruction[14:12] == 3'd0);
`endif

  // State register; reset drops any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = EXEC;
      end
      EXEC: begin
`ifdef ALU_MC_MUL_EN
        state_nxt = is_mul ? MUL : DONE;
`else
        state_nxt = DONE;
`endif
      end
`ifdef ALU_MC_MUL_EN
      MUL: begin
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
`endif
      DONE: begin
        if (bus.out_ready) begin
          in_ready  = 1'b1;
          state_nxt = bus.in_valid ? EXEC : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture at accept; inputs are never looked at again afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3 <= '0;
      alt    <= 1'b0;
      op1    <= '0;
      op2    <= '0;
`ifdef ALU_MC_MUL_EN
      is_mul <= 1'b0;
`endif
    end else if (accept) begin
      funct3 <= bus.instruction[14:12];
      alt    <= bus.instruction[30];
      op1    <= bus.in1;
      op2    <= bus.in2;
`ifdef ALU_MC_MUL_EN
      is_mul <= is_mul_in;
`endif
    end
  end

`ifdef ALU_MC_MUL_EN
  // Shift-add multiplier: bit cnt of op2 adds op1<<cnt; cleared on the EXEC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == EXEC) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == MUL) begin
      if (op2[cnt]) acc <= acc + (op1 << cnt);
      cnt <= cnt + SHW'(1);
    end
  end
`endif

  // Result select from captured operands only
  always_comb begin
`ifdef ALU_MC_MUL_EN
    result = is_mul ? acc : base_op(funct3, alt, op1, op2);
`else
    result = base_op(funct3, alt, op1, op2);
`endif
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out       = (state == DONE) ? result : '0;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc. A 64-bit and a 32-bit instance share
// the same stimulus (the 32-bit one sees the low operand halves) and are both
// compared against a width-aware arithmetic reference model.
module tb_alu_mc;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mc_if #(.XLEN(64)) bus ();
  alu_mc_if #(.XLEN(32)) bus32 ();

  alu_mc #(.XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  alu_mc #(.XLEN(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32.slave)
  );

  assign bus32.in_valid    = bus.in_valid;
  assign bus32.instruction = bus.instruction;
  assign bus32.in1         = bus.in1[31:0];
  assign bus32.in2         = bus.in2[31:0];
  assign bus32.out_ready   = bus.out_ready;

  int checks   = 0;
  int failures = 0;
  logic [63:0] last_out64;
  logic [63:0] last_out32;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 10'd0, f3, 5'd0, 7'b0110011};
  endfunction

  function automatic bit ref_is_mul(input logic [31:0] ins);
`ifdef ALU_MC_MUL_EN
    return (ins[31:25] == 7'b0000001) && (ins[14:12] == 3'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain arithmetic at width w (64 or 32)
  function automatic logic [63:0] ref_alu(input logic [31:0] ins, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input int w);
    logic [63:0]        mask, a, b, r;
    logic signed [63:0] sa, sb;
    int                 sh;
    logic [2:0]         f3;
    logic [6:0]         f7;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a  = a_in & mask;
    b  = b_in & mask;
    sa = (w == 64) ? a : {{32{a[31]}}, a[31:0]};
    sb = (w == 64) ? b : {{32{b[31]}}, b[31:0]};
    sh = (w == 64) ? int'(b[5:0]) : int'(b[4:0]);
    f3 = ins[14:12];
    f7 = ins[31:25];
    r  = 64'd0;
    if (ref_is_mul(ins)) return (a * b) & mask;
    case (f3)
      3'd0: if (f7[5]) r = a - b; else r = a + b;
      3'd1: r = a << sh;
      3'd2: r = (sa < sb) ? 64'd1 : 64'd0;
      3'd3: r = (a < b) ? 64'd1 : 64'd0;
      3'd4: r = a ^ b;
      3'd5: if (f7[5]) r = sa >>> sh; else r = a >> sh;
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r & mask;
  endfunction

  // Offer one op, follow it to DONE, optionally stall, then consume it
  task automatic run_op(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                        input int stall);
    logic [63:0] e64, e32;
    int lat, exp_lat, waited;
    e64     = ref_alu(ins, a, b, 64);
    e32     = ref_alu(ins, a, b, 32);
    exp_lat = ref_is_mul(ins) ? XLEN + 2 : 2;
    waited  = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    chk("in_ready_idle32", 64'(bus32.in_ready), 64'd1);
    bus.in_valid    = 1'b1;
    bus.instruction = ins;
    bus.in1         = a;
    bus.in2         = b;
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    bus.instruction = $urandom;
    bus.in1         = {$urandom, $urandom};
    bus.in2         = {$urandom, $urandom};
    lat = 1;
    while (!bus.out_valid && lat < XLEN + 10) begin
      chk("out_zero_not_done", bus.out, 64'd0);
      chk("busy_in_flight", 64'(bus.busy), 64'd1);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("out64", bus.out, e64);
    chk("valid32", 64'(bus32.out_valid), 64'd1);
    chk("out32", 64'(bus32.out), e32);
    last_out64 = bus.out;
    last_out32 = 64'(bus32.out);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("hold_out", bus.out, e64);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("released_valid", 64'(bus.out_valid), 64'd0);
    chk("released_out", bus.out, 64'd0);
  endtask

  initial begin
    logic [31:0] ins;
    logic [63:0] a, b;
    int seen;
    bus.in_valid    = 1'b0;
    bus.instruction = 32'd0;
    bus.in1         = 64'd0;
    bus.in2         = 64'd0;
    bus.out_ready   = 1'b0;
    last_out64      = 64'd0;
    last_out32      = 64'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_busy32", 64'(bus32.busy), 64'd0);
    chk("rst_out", bus.out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

    // Directed corner cases
    run_op(mk(7'h00, 3'd0), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    chk("add_wrap", last_out64, 64'd0);
    run_op(mk(7'h20, 3'd5), 64'h8000_0000_0000_0000, 64'h43, 1);
    chk("sra", last_out64, 64'hF000_0000_0000_0000);
    run_op(mk(7'h00, 3'd5), 64'h8000_0000_0000_0000, 64'h43, 0);
    chk("srl", last_out64, 64'h1000_0000_0000_0000);
    run_op(mk(7'h00, 3'd2), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    chk("slt", last_out64, 64'd1);
    run_op(mk(7'h00, 3'd3), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    chk("sltu", last_out64, 64'd0);
    run_op(mk(7'h00, 3'd1), 64'd1, 64'h25, 0);
    chk("sll32_shamt_mask", last_out32, 64'h20);
    chk("sll64", last_out64, 64'h20_0000_0000);
    run_op(mk(7'h20, 3'd0), 64'd5, 64'd7, 0);
    chk("sub_wrap", last_out64, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(mk(7'h01, 3'd0), 64'd7, 64'd6, 0);
`ifdef ALU_MC_MUL_EN
    chk("mul_7x6", last_out64, 64'd42);
`else
    chk("f7_01_is_add", last_out64, 64'd13);
`endif

    // Stalled XOR, then back-to-back ADD accepted in the release cycle
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.instruction = mk(7'h00, 3'd4);
    bus.in1         = 64'hF0;
    bus.in2         = 64'hFF;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("xor_valid", 64'(bus.out_valid), 64'd1);
    chk("xor_out", bus.out, 64'h0F);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("xor_hold_out", bus.out, 64'h0F);
      chk("xor_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("xor_hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.instruction = mk(7'h00, 3'd0);
    bus.in1         = 64'd100;
    bus.in2         = 64'd23;
    #1;
    chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("b2b_exec_valid", 64'(bus.out_valid), 64'd0);
    chk("b2b_exec_busy", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #1;
    chk("b2b_valid", 64'(bus.out_valid), 64'd1);
    chk("b2b_out", bus.out, 64'd123);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Randomized ops
    for (int n = 0; n < 40; n++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 2))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'h01;
      endcase
      ins = {f7, 10'($urandom), 3'($urandom_range(0, 7)), 12'($urandom)};
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 130));
      run_op(ins, a, b, $urandom_range(0, 3));
    end

    // Reset in the middle of an operation
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.instruction = mk(7'h01, 3'd0);
    bus.in1         = 64'd7;
    bus.in2         = 64'd6;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
`ifdef ALU_MC_MUL_EN
    repeat (8) @(posedge clk);
    #1;
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_out", bus.out, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 2 * XLEN; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus32.out_valid) seen++;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);

    run_op(mk(7'h00, 3'd6), 64'h1234_0000_0000_00F0, 64'h0F, 0);
    chk("or_after_rst", last_out64, 64'h1234_0000_0000_00FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute guard so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout got=0x%h exp=0x%h", 64'd0, 64'd1);
    $fatal(1, "timeout");
  end
endmodule
